// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: evaluates MIPS branch conditions, registers the taken
// decision, and drives the one-cycle PC select and a stall-aware multi-cycle flush.
// Optional accept/taken counters when BRANCH_RESOLVE_STATS_EN is defined.
module branch_resolve_unit #(
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Valid,
  input  logic             Stall,
  input  logic [2:0]       BranchOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Taken,
  output logic             PCSrc,
  output logic             Flush,
  output logic             Busy
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [31:0]      BranchCount,
  output logic [31:0]      TakenCount
`endif
);

  localparam int CW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES);

  typedef enum logic [2:0] {
    OP_BEQ    = 3'b000,
    OP_BNE    = 3'b001,
    OP_BLEZ   = 3'b010,
    OP_BGTZ   = 3'b011,
    OP_BLTZ   = 3'b100,
    OP_BGEZ   = 3'b101,
    OP_ALWAYS = 3'b110,
    OP_NEVER  = 3'b111
  } branch_op_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  state_e        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          taken_q, taken_nxt;
  logic          pcsrc_q, pcsrc_nxt;
  logic          cond;
  logic          accept;
  logic          a_neg, a_zero;

  // Signed tests only need the sign bit and a zero detect; no subtractor.
  assign a_neg  = A[WIDTH-1];
  assign a_zero = (A == '0);

  always_comb begin
    cond = 1'b0;
    case (branch_op_e'(BranchOp))
      OP_BEQ:    cond = (A == B);
      OP_BNE:    cond = (A != B);
      OP_BLEZ:   cond = a_neg | a_zero;
      OP_BGTZ:   cond = ~a_neg & ~a_zero;
      OP_BLTZ:   cond = a_neg;
      OP_BGEZ:   cond = ~a_neg;
      OP_ALWAYS: cond = 1'b1;
      OP_NEVER:  cond = 1'b0;
      default:   cond = 1'b0;
    endcase
  end

  // Valid arriving while flushing belongs to a squashed instruction.
  assign accept = Valid & ~Stall & (state == S_IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    taken_nxt = 1'b0;
    pcsrc_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && cond) begin
          state_nxt = S_FLUSH;
          cnt_nxt   = CNT_LOAD;
          taken_nxt = 1'b1;
          pcsrc_nxt = 1'b1;
        end
      end
      S_FLUSH: begin
        if (!Stall) begin
          if (cnt == CW'(1)) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      taken_q <= 1'b0;
      pcsrc_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      taken_q <= taken_nxt;
      pcsrc_q <= pcsrc_nxt;
    end
  end

  assign Taken = taken_q;
  assign PCSrc = pcsrc_q;
  assign Flush = (state == S_FLUSH);
  assign Busy  = (state == S_FLUSH);

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] branch_cnt, taken_cnt;

  // Accept already excludes stalled cycles, so the counters hold during Stall.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (accept) begin
      if (branch_cnt != 32'hFFFF_FFFF) branch_cnt <= branch_cnt + 32'd1;
      if (cond && taken_cnt != 32'hFFFF_FFFF) taken_cnt <= taken_cnt + 32'd1;
    end
  end

  assign BranchCount = branch_cnt;
  assign TakenCount  = taken_cnt;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;
  localparam int WIDTH = 32;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             Valid;
  logic             Stall;
  logic [2:0]       BranchOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Taken, PCSrc, Flush, Busy;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0]      BranchCount, TakenCount;
`endif

  int checks = 0;
  int errors = 0;

  branch_resolve_unit #(.WIDTH(WIDTH), .FLUSH_CYCLES(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Valid(Valid), .Stall(Stall),
    .BranchOp(BranchOp), .A(A), .B(B),
    .Taken(Taken), .PCSrc(PCSrc), .Flush(Flush), .Busy(Busy)
`ifdef BRANCH_RESOLVE_STATS_EN
    , .BranchCount(BranchCount), .TakenCount(TakenCount)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic t, input logic p, input logic f);
    chk({tag, ".taken"}, {31'd0, Taken}, {31'd0, t});
    chk({tag, ".pcsrc"}, {31'd0, PCSrc}, {31'd0, p});
    chk({tag, ".flush"}, {31'd0, Flush}, {31'd0, f});
    chk({tag, ".busy"},  {31'd0, Busy},  {31'd0, f});
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Valid = v; BranchOp = op; A = a; B = b;
  endtask

  // op, A, B, expected taken
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{3'b100, 32'h8000_0000, 32'h0, 1'b1};  // BLTZ min
    vecs[1] = '{3'b101, 32'h8000_0000, 32'h0, 1'b0};  // BGEZ min
    vecs[2] = '{3'b010, 32'h0000_0000, 32'h0, 1'b1};  // BLEZ zero
    vecs[3] = '{3'b011, 32'h0000_0000, 32'h0, 1'b0};  // BGTZ zero
    vecs[4] = '{3'b010, 32'hFFFF_FFFF, 32'h5, 1'b1};  // BLEZ -1
    vecs[5] = '{3'b011, 32'h7FFF_FFFF, 32'h0, 1'b1};  // BGTZ max
    vecs[6] = '{3'b111, 32'h0000_0000, 32'h0, 1'b0};  // NEVER
    vecs[7] = '{3'b000, 32'h0000_0001, 32'h2, 1'b0};  // BEQ diff
    vecs[8] = '{3'b001, 32'h0000_0001, 32'h2, 1'b1};  // BNE diff
    vecs[9] = '{3'b101, 32'h0000_0000, 32'h0, 1'b1};  // BGEZ zero

    Reset_n = 1'b0; Stall = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    outs("reset", 1'b0, 1'b0, 1'b0);
    #13 Reset_n = 1'b1;
    step();

    // BEQ equal: PC select one cycle, flush two cycles
    drive(1'b1, 3'b000, 32'h0000_1234, 32'h0000_1234);
    step(); outs("beq.c1", 1'b1, 1'b1, 1'b1);
    Valid = 1'b0;
    step(); outs("beq.c2", 1'b0, 1'b0, 1'b1);
    step(); outs("beq.c3", 1'b0, 1'b0, 1'b0);

    // BNE not taken, then BGTZ accepted on the very next cycle
    drive(1'b1, 3'b001, 32'h5, 32'h5);
    step(); outs("bne", 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'b011, 32'h1, 32'h0);
    step(); outs("bgtz", 1'b1, 1'b1, 1'b1);
    Valid = 1'b0;
    step(); step(); outs("bgtz.done", 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      step();
      chk($sformatf("vec%0d.taken", i), {31'd0, Taken}, {31'd0, vecs[i].exp});
      chk($sformatf("vec%0d.flush", i), {31'd0, Flush}, {31'd0, vecs[i].exp});
      Valid = 1'b0;
      step(); step();
    end

    // Stall in IDLE blocks accept
    Stall = 1'b1;
    drive(1'b1, 3'b110, 32'h0, 32'h0);
    step(); outs("idle.stall", 1'b0, 1'b0, 1'b0);
    Stall = 1'b0; Valid = 1'b0;
    step(); outs("idle.stall.rel", 1'b0, 1'b0, 1'b0);

    // Taken branch, 3 stalled cycles while flushing, Valid BEQ ignored
    drive(1'b1, 3'b000, 32'hA, 32'hA);
    step(); outs("stl.c1", 1'b1, 1'b1, 1'b1);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); outs($sformatf("stl.hold%0d", i), 1'b0, 1'b0, 1'b1);
    end
    Stall = 1'b0; Valid = 1'b0;
    step(); outs("stl.c5", 1'b0, 1'b0, 1'b1);
    step(); outs("stl.end", 1'b0, 1'b0, 1'b0);

    // Async reset mid-flush
    drive(1'b1, 3'b110, 32'h0, 32'h0);
    step(); outs("rst.pre", 1'b1, 1'b1, 1'b1);
    Valid = 1'b0;
    #2 Reset_n = 1'b0;
    #1 outs("rst.async", 1'b0, 1'b0, 1'b0);
    #1 Reset_n = 1'b1;
    drive(1'b1, 3'b110, 32'h0, 32'h0);
    step(); outs("rst.always", 1'b1, 1'b1, 1'b1);
    // Valid held high while flushing: ignored
    step(); outs("rst.ign", 1'b0, 1'b0, 1'b1);
    step(); outs("rst.idle", 1'b0, 1'b0, 1'b0);
    // Valid still high: accepted again once back in IDLE
    step(); outs("rst.again", 1'b1, 1'b1, 1'b1);
    Valid = 1'b0;
    step(); step();

`ifdef BRANCH_RESOLVE_STATS_EN
    Reset_n = 1'b0;
    #1 chk("stats.rst.bc", BranchCount, 32'd0);
    chk("stats.rst.tc", TakenCount, 32'd0);
    #2 Reset_n = 1'b1;
    drive(1'b1, 3'b110, 32'h0, 32'h0);   // taken
    step(); drive(1'b1, 3'b000, 32'h3, 32'h3);  // ignored in flush
    step(); Valid = 1'b0; step();
    drive(1'b1, 3'b111, 32'h0, 32'h0);   // not taken
    step(); drive(1'b1, 3'b000, 32'h7, 32'h7);  // taken
    step(); Valid = 1'b0; Stall = 1'b1; step(); step();
    Stall = 1'b0; step(); step();
    drive(1'b1, 3'b101, 32'h0, 32'h0);   // taken
    step(); Valid = 1'b0; step(); step();
    chk("stats.bc", BranchCount, 32'd4);
    chk("stats.tc", TakenCount, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL timeout: got no finish expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised, registered successor to the single-gate branch qualifier (Branch AND Zero) in the pipelined MIPS datapath.
- Evaluates all MIPS conditional branch types on two WIDTH-bit operands in the EX stage and registers the taken decision.
- Generates the PC-select pulse and a multi-cycle flush for the fetch/decode stages.
- Accepts stalls from the hazard unit.

Parameters:
- WIDTH, 32, operand width in bits (>=2).
- FLUSH_CYCLES, 2, cycles Flush stays asserted after a taken branch (>=1).

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- Valid  input  1  EX-stage instruction is a branch/jump to resolve.
- Stall  input  1  pipeline stall from hazard unit; freezes this block.
- BranchOp  input  3  condition select (encoding below).
- A  input  WIDTH  rs operand (two's complement).
- B  input  WIDTH  rt operand.
- Taken  output  1  registered one-cycle pulse: accepted branch resolved taken.
- PCSrc  output  1  registered; selects branch target in fetch for exactly one cycle.
- Flush  output  1  registered; squashes IF/ID contents while high.
- Busy  output  1  high while in FLUSH state.

Behaviour:
- Reset: Reset_n low asynchronously forces Taken=0, PCSrc=0, Flush=0, Busy=0, state=IDLE, counter=0. This applies at any time, including mid-flush. Operation resumes on the first rising edge after release.
- BranchOp encoding:
  - 000 BEQ: A==B.
  - 001 BNE: A!=B.
  - 010 BLEZ: signed A<=0.
  - 011 BGTZ: signed A>0.
  - 100 BLTZ: A[WIDTH-1]==1.
  - 101 BGEZ: A[WIDTH-1]==0.
  - 110 ALWAYS (J/JAL/JR).
  - 111 NEVER.
- Signed rules: signed compares use the MSB as sign. B is ignored for opcodes 010-111. No arithmetic overflow is possible because there is no subtraction; use direct compare.
- Accept: a branch is accepted on an edge where Valid=1, Stall=0 and state=IDLE. The condition is evaluated combinationally from the current inputs.
- Latency 1: the cycle after accept, Taken equals the condition result. Taken is 0 in every other cycle.
- States IDLE and FLUSH:
  - IDLE -> FLUSH on accept with condition true.
    - Load counter = FLUSH_CYCLES.
    - Next cycle: Taken=1, PCSrc=1, Flush=1, Busy=1.
  - In FLUSH:
    - Flush=1 and Busy=1.
    - PCSrc=1 only in the first FLUSH cycle.
    - Counter decrements on each edge with Stall=0 and holds when Stall=1. Flush remains high throughout the hold.
    - FLUSH -> IDLE on the edge where counter==1 and Stall=0.
  - Result: Flush is high for exactly FLUSH_CYCLES non-stalled cycles.
- Valid during FLUSH is ignored (that instruction is being squashed). No decision is produced for it.
- Stall in IDLE: no accept, no outputs change. Taken, PCSrc and Flush stay 0.
- Stall=1 on the cycle PCSrc is high: PCSrc still deasserts after one cycle. Fetch captures the target on the PCSrc cycle regardless of stall.
- Not-taken accept: outputs stay 0, remain in IDLE. A new branch may be accepted on the very next cycle.
- Back-to-back: a taken branch followed by another Valid on the next cycle — the second is ignored, because state is FLUSH.

Optional Feature:
- Macro: BRANCH_RESOLVE_STATS_EN.
- When defined, two extra outputs exist:
  - BranchCount (32-bit): increments on every accept.
  - TakenCount (32-bit): increments on every taken accept.
  - Both saturate at 0xFFFFFFFF, reset to 0 with Reset_n, and hold during Stall.
- When undefined, these ports and their registers are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then BEQ with A=B=0x0000_1234, Valid=1, FLUSH_CYCLES=2 -> next cycle Taken=1, PCSrc=1, Flush=1. Following cycle PCSrc=0, Flush=1. Then all 0, Busy low.
- BNE with A=B=0x5 -> Taken=0, PCSrc=0, Flush=0. A BGTZ with A=0x1 on the next cycle is accepted and taken.
- BLTZ A=0x8000_0000 -> taken. BGEZ A=0x8000_0000 -> not taken. BLEZ A=0 -> taken. BGTZ A=0 -> not taken.
- Taken branch; Stall=1 for 3 cycles during FLUSH -> Flush stays 1 for 2+3=5 cycles. PCSrc high exactly 1 cycle. Valid=1 BEQ (equal) during FLUSH produces no second Taken.
- Reset_n pulsed low mid-FLUSH -> Flush, Busy and PCSrc drop immediately (asynchronously). After release, an ALWAYS op is accepted normally.
- With BRANCH_RESOLVE_STATS_EN: 4 accepts with 3 taken -> BranchCount=4, TakenCount=3. Ignored-during-flush Valids are not counted.
